imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of the first word written.
REQ-002 SHALL have parameter MAX_WORDS, default 16384, largest accepted program length in words (64KB).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a load.
REQ-006 SHALL have port in_valid  input  1  source has a byte on in_data.
REQ-007 SHALL have port in_data  input  8  serial program byte.
REQ-008 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port mem_we  output  1  single-cycle instruction-memory write strobe.
REQ-010 SHALL have port mem_addr  output  32  byte address of the write; bits [1:0] always 00.
REQ-011 SHALL have port mem_wdata  output  32  instruction word being written.
REQ-012 SHALL have port busy  output  1  load in progress.
REQ-013 SHALL have port done  output  1  sticky, load completed successfully.
REQ-014 SHALL have port err  output  1  sticky, load aborted.
REQ-015 SHALL have port words_written  output  15  count of words written in the current load.

Function
REQ-016 SHALL transfer a byte only in a cycle where in_valid and in_ready are both 1.
REQ-017 SHALL implement states IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERROR.
REQ-018 SHALL move IDLE/DONE/ERROR -> LEN_LO on start, clearing done, err, words_written and byte lane; start SHALL be ignored in every other state.
REQ-019 SHALL assert in_ready only in LEN_LO, LEN_HI, DATA and CHK.
REQ-020 SHALL take the 16-bit word count N little-endian: LEN_LO byte -> N[7:0], LEN_HI byte -> N[15:8].
REQ-021 SHALL go from LEN_HI to ERROR (err=1) if N==0 or N>MAX_WORDS, otherwise to DATA.
REQ-022 SHALL assemble each word little-endian: 1st byte -> [7:0], 2nd -> [15:8], 3rd -> [23:16], 4th -> [31:24].
REQ-023 SHALL, in the cycle after the 4th byte is accepted, pulse mem_we for exactly one cycle with mem_addr = BASE_ADDR + 4*words_written (pre-increment) and the completed word on mem_wdata, then increment words_written.
REQ-024 SHALL keep mem_wdata in a register separate from the assembly register, so in_ready stays 1 during the write cycle and back-to-back bytes sustain one byte per clock.
REQ-025 SHALL hold mem_we 0, and mem_addr and mem_wdata at their last value, outside write cycles.
REQ-026 SHALL leave DATA after the byte that completes word N, with the final mem_we still issued per REQ-023.
REQ-027 SHALL assert busy in LEN_LO, LEN_HI, DATA and CHK, and in the final write cycle.
REQ-028 SHALL assert done the cycle after the final mem_we (checksum disabled) and hold it until the next start or reset.
REQ-029 SHALL never write beyond address BASE_ADDR + 4*(MAX_WORDS-1); no address wrap-around occurs.

Reset
REQ-030 SHALL on rst_n=0, immediately and regardless of clk, enter IDLE, clear all counters and registers, and drive in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, words_written=0.
REQ-031 SHALL, if reset occurs mid-load, discard any partial word and issue no further write.

Configuration
REQ-032 SHALL, with macro IMEM_LOADER_CHECKSUM_EN defined, go from DATA to CHK after word N and accept one trailing byte; it SHALL go to DONE if that byte equals the XOR of all data bytes (length bytes excluded), else to ERROR with err=1.
REQ-033 SHALL, without IMEM_LOADER_CHECKSUM_EN, omit the CHK state and XOR logic and go from DATA directly to DONE.

Verification
REQ-034 SHALL cover: start, bytes 02 00 13 00 00 00 93 00 10 00 with valid held high -> mem_we at 0x0 data 0x00000013, then at 0x4 data 0x00100093; done=1; words_written=2.
REQ-035 SHALL cover: length bytes 00 00, and separately 01 40 (N=16385) -> ERROR, err=1, no mem_we, in_ready=0.
REQ-036 SHALL cover: random in_valid gaps during a 3-word load -> identical writes to the gap-free run; no byte lost or duplicated.
REQ-037 SHALL cover: rst_n low after 6 data bytes -> outputs at reset values, no write for the partial word; a fresh load then succeeds from address BASE_ADDR.
REQ-038 SHALL cover, with IMEM_LOADER_CHECKSUM_EN: word 0x00000013 plus checksum 0x13 -> done=1; checksum 0x12 -> err=1, done=0.
REQ-039 SHALL cover: start pulsed during DATA -> ignored, load completes normally.

Source files
------------

// File: rtl/imem_loader.sv
// Serial byte-stream loader that fills instruction memory with little-endian 32-bit words.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 16384
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [14:0] words_written
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CHK    = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    state_t      state_r;
    logic [7:0]  len_lo_r;
    logic [15:0] len_r;
    logic [23:0] asm_r;
    logic [1:0]  lane_r;
    logic [14:0] words_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic        we_r;
    logic        ready_r;
    logic        busy_r;
    logic        done_r;
    logic        err_r;
    logic        fin_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  chk_r;
`endif

    logic        xfer_s;
    logic [15:0] len_s;
    logic        len_bad_s;
    logic        last_s;

    function automatic logic [31:0] word_addr(input logic [14:0] idx);
        word_addr = BASE_ADDR + {15'd0, idx, 2'b00};
    endfunction

    assign xfer_s    = in_valid && ready_r;
    assign len_s     = {in_data, len_lo_r};
    assign len_bad_s = (len_s == 16'd0) || ({1'b0, len_s} > MAX_N);
    // words_r already holds the count of completed writes when the 4th byte of the next word lands
    assign last_s    = (({1'b0, words_r}) + 16'd1) == len_r;

    // Loader FSM; every output is a register updated here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            len_lo_r <= 8'd0;
            len_r    <= 16'd0;
            asm_r    <= 24'd0;
            lane_r   <= 2'd0;
            words_r  <= 15'd0;
            addr_r   <= 32'd0;
            wdata_r  <= 32'd0;
            we_r     <= 1'b0;
            ready_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            fin_r    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_r    <= 8'd0;
`endif
        end else begin
            we_r <= 1'b0;
            if (we_r) begin
                words_r <= words_r + 15'd1;
            end
            if (fin_r) begin
                fin_r  <= 1'b0;
                done_r <= 1'b1;
                busy_r <= 1'b0;
            end

            case (state_r)
                IDLE, DONE, ERROR: begin
                    // Placed after the write/finish bookkeeping so a restart overrides it
                    if (start) begin
                        state_r <= LEN_LO;
                        done_r  <= 1'b0;
                        err_r   <= 1'b0;
                        words_r <= 15'd0;
                        lane_r  <= 2'd0;
                        fin_r   <= 1'b0;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chk_r   <= 8'd0;
`endif
                    end
                end
                LEN_LO: begin
                    if (xfer_s) begin
                        len_lo_r <= in_data;
                        state_r  <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (xfer_s) begin
                        if (len_bad_s) begin
                            state_r <= ERROR;
                            err_r   <= 1'b1;
                            ready_r <= 1'b0;
                            busy_r  <= 1'b0;
                        end else begin
                            len_r   <= len_s;
                            state_r <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chk_r <= chk_r ^ in_data;
`endif
                        lane_r <= lane_r + 2'd1;
                        case (lane_r)
                            2'd0: asm_r[7:0]   <= in_data;
                            2'd1: asm_r[15:8]  <= in_data;
                            2'd2: asm_r[23:16] <= in_data;
                            2'd3: begin
                                we_r    <= 1'b1;
                                addr_r  <= word_addr(words_r);
                                wdata_r <= {in_data, asm_r};
                                if (last_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                    state_r <= CHK;
`else
                                    state_r <= DONE;
                                    ready_r <= 1'b0;
                                    fin_r   <= 1'b1;
`endif
                                end
                            end
                            default: lane_r <= 2'd0;
                        endcase
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK: begin
                    if (xfer_s) begin
                        ready_r <= 1'b0;
                        busy_r  <= 1'b0;
                        if (in_data == chk_r) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ERROR;
                            err_r   <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready      = ready_r;
    assign mem_we        = we_r;
    assign mem_addr      = addr_r;
    assign mem_wdata     = wdata_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign err           = err_r;
    assign words_written = words_r;

endmodule
